// File: rtl/fp_rsqrte_arb.sv
// ---------------------------------------------------------------------------
// fp_rsqrte_arb
//
// Round-robin arbiter that shares one pipelined reciprocal-square-root
// estimate unit between NREQ requesters. One operation is in flight at a
// time. A four-state sequencer (IDLE -> ISSUE -> WAIT -> DONE) grants a
// requester, launches its operand into the unit, waits LATENCY enabled
// cycles and returns the result with a one-cycle completion pulse.
//
// Parameters
//   NREQ     number of requesters (2..8)
//   FPWID    operand / result width
//   LATENCY  unit latency in ru_ce-enabled cycles from ru_ld to valid ru_o
//            (2..63)
//
// Ports
//   clk    in   sole clock, rising edge
//   rst_n  in   synchronous active-low reset
//   stall  in   freeze: holds the sequencer and drops ru_ce
//   req    in   NREQ    per-requester request level
//   a      in   NREQ*FPWID operands, requester i at [i*FPWID +: FPWID]
//   ack    out  NREQ    one-hot acceptance pulse (ISSUE cycle)
//   done   out  NREQ    one-hot completion pulse (DONE cycle)
//   res    out  FPWID   result, valid with done, held until next capture
//   busy   out  1       sequencer is not IDLE
//   ru_ld  out  1       load strobe to the estimate unit
//   ru_ce  out  1       clock enable to the estimate unit (~stall)
//   ru_a   out  FPWID   registered operand to the estimate unit
//   ru_o   in   FPWID   estimate unit result
// ---------------------------------------------------------------------------
module fp_rsqrte_arb #(
  parameter int NREQ    = 4,
  parameter int FPWID   = 80,
  parameter int LATENCY = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*FPWID-1:0] a,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       done,
  output logic [FPWID-1:0]      res,
  output logic                  busy,
  output logic                  ru_ld,
  output logic                  ru_ce,
  output logic [FPWID-1:0]      ru_a,
  input  logic [FPWID-1:0]      ru_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   g;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] g_onehot;

  // Operand bus viewed as an array so the grant index selects a lane.
  logic [FPWID-1:0] a_arr [NREQ];

  logic            hi_found;
  logic            lo_found;
  logic [PW-1:0]   hi_idx;
  logic [PW-1:0]   lo_idx;
  logic            grant_found;
  logic [PW-1:0]   grant_idx;

  logic grant_fire;
  logic issue_fire;
  logic wait_tick;
  logic capture;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = a[i*FPWID +: FPWID];
    end
  end

  // -------------------------------------------------------------------------
  // Round-robin pick. Two priority searches run in parallel: the lowest set
  // request at or above ptr, and the lowest set request overall. The first
  // wins when it exists; otherwise the search has wrapped past NREQ-1 and
  // the overall lowest is the next in turn. Scanning downwards lets the
  // last assignment be the lowest index.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in an always_comb gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_found = 1'b1;
        lo_idx   = PW'(i);
        if (PW'(i) >= ptr) begin
          hi_found = 1'b1;
          hi_idx   = PW'(i);
        end
      end
    end
    grant_found = lo_found;
    grant_idx   = hi_found ? hi_idx : lo_idx;
  end

  // -------------------------------------------------------------------------
  // Next-state and strobes.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    grant_fire = 1'b0;
    issue_fire = 1'b0;
    wait_tick  = 1'b0;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!stall && grant_found) begin
          grant_fire = 1'b1;
          state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        if (!stall) begin
          issue_fire = 1'b1;
          state_nxt  = WAIT;
        end
      end
      WAIT: begin
        if (!stall) begin
          wait_tick = 1'b1;
          if (cnt == '0) begin
            capture   = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        // Completion is not stallable; no grant is considered here.
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State register.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath and bookkeeping registers.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: the wide operand/result registers are reset along with the
    // control state, so an abandoned operation leaves no stale data visible.
    if (!rst_n) begin
      ptr  <= '0;
      g    <= '0;
      cnt  <= '0;
      done <= '0;
      res  <= '0;
      ru_a <= '0;
    end else begin
      done <= '0;

      if (grant_fire) begin
        g    <= grant_idx;
        ru_a <= a_arr[grant_idx];
        ptr  <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
      end

      // The counter is loaded on the launch and steps only on enabled
      // cycles, so it tracks the unit's own ru_ce-gated pipeline.
      if (issue_fire) begin
        cnt <= CW'(LATENCY - 1);
      end else if (wait_tick && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end

      // done is registered from the capture decision, so it appears exactly
      // in the DONE cycle together with the freshly captured result.
      if (capture) begin
        res  <= ru_o;
        done <= g_onehot;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs.
  // ack/ru_ld are decoded from the registered state and grant index; they are
  // gated by the current stall so a frozen ISSUE cycle launches nothing.
  // -------------------------------------------------------------------------
  assign g_onehot = NREQ'(1) << g;
  assign ru_ld    = issue_fire;
  assign ack      = issue_fire ? g_onehot : '0;
  assign busy     = (state != IDLE);
  assign ru_ce    = ~stall;

endmodule

// File: tb/tb_fp_rsqrte_arb.sv
// ---------------------------------------------------------------------------
// tb_fp_rsqrte_arb
//
// Self-checking bench for fp_rsqrte_arb (NREQ=4, FPWID=80, LATENCY=28).
// Directed table of single grants, hand-written multi-cycle sequences
// (simultaneous requests, fairness, stalls, mid-operation reset) and a
// randomized run checked against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_fp_rsqrte_arb;

  localparam int NREQ    = 4;
  localparam int FPWID   = 80;
  localparam int LATENCY = 28;

  logic                  clk;
  logic                  rst_n;
  logic                  stall;
  logic [NREQ-1:0]       req;
  logic [NREQ*FPWID-1:0] a;
  logic [NREQ-1:0]       ack;
  logic [NREQ-1:0]       done;
  logic [FPWID-1:0]      res;
  logic                  busy;
  logic                  ru_ld;
  logic                  ru_ce;
  logic [FPWID-1:0]      ru_a;
  logic [FPWID-1:0]      ru_o;

  int n_checks;
  int n_fail;
  int cyc;

  fp_rsqrte_arb #(
    .NREQ   (NREQ),
    .FPWID  (FPWID),
    .LATENCY(LATENCY)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .stall(stall),
    .req  (req),
    .a    (a),
    .ack  (ack),
    .done (done),
    .res  (res),
    .busy (busy),
    .ru_ld(ru_ld),
    .ru_ce(ru_ce),
    .ru_a (ru_a),
    .ru_o (ru_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    return NREQ'(1) << i;
  endfunction

  // Move to the start of the next cycle, where inputs may be driven.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    stall = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  // Wait (from the current cycle, inclusive) for a non-zero ack; returns the
  // cycle index or -1 when the bound expires. Leaves time at that negedge.
  task automatic wait_ack(input int limit, output int at, output logic [NREQ-1:0] v);
    at = -1;
    v  = '0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (ack != '0) begin
        at = cyc;
        v  = ack;
        break;
      end
    end
  endtask

  task automatic wait_done(input int limit, output int at, output logic [NREQ-1:0] v);
    at = -1;
    v  = '0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (done != '0) begin
        at = cyc;
        v  = done;
        break;
      end
    end
  endtask

  function automatic logic [FPWID-1:0] lane_val(input logic [FPWID-1:0] base, input int i);
    return base + FPWID'(i * 32'h1111);
  endfunction

  // ---------------------------------------------------------------------
  // Directed table: each record is applied to an idle DUT. Expected grant
  // indices account for the pointer left behind by the previous record.
  // ---------------------------------------------------------------------
  typedef struct packed {
    logic [NREQ-1:0]  req;
    logic [FPWID-1:0] op;
    logic [FPWID-1:0] ro;
    logic [2:0]       g;
  } vec_t;

  vec_t tbl [9];

  // ---------------------------------------------------------------------
  // Reference model for the random run: tracks one transaction by counting
  // enabled cycles; knows nothing about the DUT's encoding.
  // ---------------------------------------------------------------------
  bit               m_active;
  bit               m_ack_pending;
  bit               m_done_now;
  int               m_left;
  int               m_g;
  int               m_ptr;
  logic [FPWID-1:0] m_res;
  logic [FPWID-1:0] m_ru_a;
  logic [NREQ-1:0]  m_ack_seen;

  task automatic model_reset();
    m_active      = 0;
    m_ack_pending = 0;
    m_done_now    = 0;
    m_left        = 0;
    m_g           = 0;
    m_ptr         = 0;
    m_res         = '0;
    m_ru_a        = '0;
    m_ack_seen    = '0;
  endtask

  // Called at the negedge of every cycle of the random run.
  task automatic model_step();
    logic [NREQ-1:0] e_ack;
    logic [NREQ-1:0] e_done;
    logic            e_ld;
    e_ack  = '0;
    e_done = '0;
    e_ld   = 1'b0;
    check("rnd_busy", busy, m_active);
    check("rnd_res", res, m_res);
    check("rnd_ru_a", ru_a, m_ru_a);
    check("rnd_ru_ce", ru_ce, !stall);
    if (m_done_now) begin
      e_done     = oh(m_g);
      m_done_now = 0;
      m_active   = 0;
    end else if (m_active && m_ack_pending) begin
      if (!stall) begin
        e_ack         = oh(m_g);
        e_ld          = 1'b1;
        m_ack_pending = 0;
        m_left        = LATENCY;
      end
    end else if (m_active) begin
      if (!stall) begin
        m_left--;
        if (m_left == 0) begin
          m_res      = ru_o;
          m_done_now = 1;
        end
      end
    end else if (!stall && req != '0) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (req[idx]) begin
          m_g = idx;
          break;
        end
      end
      m_active      = 1;
      m_ack_pending = 1;
      m_ptr         = (m_g + 1) % NREQ;
      m_ru_a        = a[m_g*FPWID +: FPWID];
    end
    check("rnd_ack", ack, e_ack);
    check("rnd_done", done, e_done);
    check("rnd_ru_ld", ru_ld, e_ld);
    m_ack_seen = e_ack;
  endtask

  initial begin
    int               t0;
    int               at;
    int               at2;
    logic [NREQ-1:0]  v;
    logic [NREQ-1:0]  v2;
    int               ack_at [5];
    logic [NREQ-1:0]  ack_v [5];
    logic [NREQ-1:0]  pend;
    logic [FPWID-1:0] rv;

    n_checks = 0;
    n_fail   = 0;
    a        = '0;
    ru_o     = '0;

    tbl[0] = '{req: 4'b0001, op: 80'h3F80_0000_0000_0000_0001, ro: 80'h3F80_8000_0000_0000_0000, g: 3'd0};
    tbl[1] = '{req: 4'b0101, op: 80'h4000_1234_5678_9ABC_DEF0, ro: 80'h3FFE_B504_F333_F9DE_6484, g: 3'd2};
    tbl[2] = '{req: 4'b1001, op: 80'h4001_0000_0000_0000_0000, ro: 80'h3FFE_8000_0000_0000_0000, g: 3'd3};
    tbl[3] = '{req: 4'b1001, op: 80'h4002_0000_0000_0000_0000, ro: 80'h3FFD_B504_F333_F9DE_6484, g: 3'd0};
    tbl[4] = '{req: 4'b0001, op: 80'h0000_0000_0000_0000_0001, ro: 80'h7FFF_FFFF_FFFF_FFFF_FFFF, g: 3'd0};
    tbl[5] = '{req: 4'b1110, op: 80'hFFFF_FFFF_FFFF_FFFF_FFFF, ro: 80'h0000_0000_0000_0000_0000, g: 3'd1};
    tbl[6] = '{req: 4'b0011, op: 80'h1234_5678_9ABC_DEF0_1234, ro: 80'hAAAA_5555_AAAA_5555_AAAA, g: 3'd0};
    tbl[7] = '{req: 4'b1000, op: 80'h5555_AAAA_5555_AAAA_5555, ro: 80'h0123_4567_89AB_CDEF_0123, g: 3'd3};
    tbl[8] = '{req: 4'b1111, op: 80'h3C00_0000_0000_0000_0000, ro: 80'h4110_0000_0000_0000_0000, g: 3'd0};

    // ---------------- reset state; ru_ce follows stall during reset ------
    rst_n = 1'b0;
    req   = '0;
    stall = 1'b1;
    next_cycle();
    @(negedge clk);
    check("rst_ru_ce_stalled", ru_ce, 1'b0);
    next_cycle();
    stall = 1'b0;
    @(negedge clk);
    check("rst_ru_ce_free", ru_ce, 1'b1);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ack", ack, '0);
    check("rst_done", done, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_ru_ld", ru_ld, 1'b0);
    check("rst_res", res, '0);
    check("rst_ru_a", ru_a, '0);

    // ---------------- table-driven single grants -------------------------
    foreach (tbl[n]) begin
      next_cycle();
      t0   = cyc;
      req  = tbl[n].req;
      for (int i = 0; i < NREQ; i++) a[i*FPWID +: FPWID] = lane_val(tbl[n].op, i);
      ru_o = tbl[n].ro;
      wait_ack(5, at, v);
      check("tbl_ack_val", v, oh(int'(tbl[n].g)));
      check("tbl_ack_lat", at - t0, 1);
      check("tbl_ru_ld", ru_ld, 1'b1);
      check("tbl_ru_a", ru_a, lane_val(tbl[n].op, int'(tbl[n].g)));
      next_cycle();
      req = '0;
      wait_done(LATENCY + 10, at2, v2);
      check("tbl_done_val", v2, oh(int'(tbl[n].g)));
      check("tbl_done_lat", at2 - t0, LATENCY + 2);
      check("tbl_res", res, tbl[n].ro);
      check("tbl_ru_a_hold", ru_a, lane_val(tbl[n].op, int'(tbl[n].g)));
      @(negedge clk);
      check("tbl_busy_after", busy, 1'b0);
    end

    // ---------------- simultaneous requests 0101 from ptr=0 --------------
    do_reset();
    t0 = cyc;
    req = 4'b0101;
    ru_o = 80'h3F80_8000_0000_0000_0000;
    wait_ack(5, at, v);
    check("sim_first_ack", v, 4'b0001);
    check("sim_first_ack_lat", at - t0, 1);
    next_cycle();
    req = 4'b0100;
    wait_done(LATENCY + 10, at2, v2);
    check("sim_first_done", v2, 4'b0001);
    check("sim_first_done_lat", at2 - t0, LATENCY + 2);
    wait_ack(10, at, v);
    check("sim_second_ack", v, 4'b0100);
    check("sim_second_ack_lat", at - t0, LATENCY + 4);
    next_cycle();
    req = '0;
    wait_done(LATENCY + 10, at2, v2);
    check("sim_second_done", v2, 4'b0100);

    // ---------------- fairness: all requests held high -------------------
    do_reset();
    t0 = cyc;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(LATENCY + 10, ack_at[k], ack_v[k]);
    end
    check("fair_first_lat", ack_at[0] - t0, 1);
    for (int k = 0; k < 5; k++) begin
      check("fair_order", ack_v[k], oh(k % NREQ));
      if (k > 0) check("fair_spacing", ack_at[k] - ack_at[k-1], LATENCY + 3);
    end
    next_cycle();
    req = '0;
    wait_done(LATENCY + 10, at2, v2);
    check("fair_last_done", v2, 4'b0001);

    // ---------------- stall for 5 cycles during WAIT ---------------------
    do_reset();
    t0 = cyc;
    req = 4'b0001;
    ru_o = 80'h1111_2222_3333_4444_5555;
    wait_ack(5, at, v);
    check("stw_ack", v, 4'b0001);
    next_cycle();
    req = '0;
    while (cyc < t0 + 10) next_cycle();
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stw_ru_ce_low", ru_ce, 1'b0);
      check("stw_no_done", done, '0);
      next_cycle();
    end
    stall = 1'b0;
    @(negedge clk);
    check("stw_ru_ce_high", ru_ce, 1'b1);
    wait_done(LATENCY + 10, at2, v2);
    check("stw_done_val", v2, 4'b0001);
    check("stw_done_lat", at2 - t0, LATENCY + 2 + 5);
    check("stw_res", res, 80'h1111_2222_3333_4444_5555);

    // ---------------- stall for 2 cycles in ISSUE ------------------------
    next_cycle();
    t0 = cyc;
    req = 4'b0010;
    next_cycle();
    stall = 1'b1;
    @(negedge clk);
    check("sti_no_ack_1", ack, '0);
    check("sti_no_ld_1", ru_ld, 1'b0);
    check("sti_busy", busy, 1'b1);
    next_cycle();
    @(negedge clk);
    check("sti_no_ack_2", ack, '0);
    next_cycle();
    stall = 1'b0;
    wait_ack(5, at, v);
    check("sti_ack_val", v, 4'b0010);
    check("sti_ack_lat", at - t0, 3);
    check("sti_ld", ru_ld, 1'b1);
    next_cycle();
    req = '0;
    wait_done(LATENCY + 10, at2, v2);
    check("sti_done_lat", at2 - t0, LATENCY + 2 + 2);

    // ---------------- reset mid-WAIT -------------------------------------
    next_cycle();
    t0 = cyc;
    req = 4'b0001;
    ru_o = 80'h0F0F_0F0F_0F0F_0F0F_0F0F;
    wait_ack(5, at, v);
    next_cycle();
    req = '0;
    while (cyc < t0 + 10) next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_ack", ack, '0);
    check("mrst_done", done, '0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_ru_ld", ru_ld, 1'b0);
    check("mrst_res", res, '0);
    check("mrst_ru_a", ru_a, '0);
    wait_done(LATENCY + 10, at2, v2);
    check("mrst_no_done", at2, -1);
    // ptr was 1 before reset; a cleared ptr serves requester 0 first.
    next_cycle();
    t0 = cyc;
    req = 4'b0011;
    wait_ack(5, at, v);
    check("mrst_ptr_cleared", v, 4'b0001);
    next_cycle();
    req = 4'b0010;
    wait_done(LATENCY + 10, at2, v2);
    wait_ack(10, at, v);
    check("mrst_new_req_ack", v, 4'b0010);
    check("mrst_new_req_lat", at - t0, LATENCY + 4);
    next_cycle();
    req = '0;
    wait_done(LATENCY + 10, at2, v2);
    check("mrst_new_req_done", v2, 4'b0010);

    // ---------------- randomized run against the model ------------------
    do_reset();
    model_reset();
    pend = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i] && m_ack_seen[i]) begin
          if ($urandom_range(1, 0) == 1) begin
            rv = {16'($urandom), $urandom, $urandom};
            a[i*FPWID +: FPWID] = rv;
          end else begin
            pend[i] = 1'b0;
          end
        end else if (!pend[i] && $urandom_range(7, 0) == 0) begin
          pend[i] = 1'b1;
          rv = {16'($urandom), $urandom, $urandom};
          a[i*FPWID +: FPWID] = rv;
        end
      end
      req   = pend;
      stall = ($urandom_range(5, 0) == 0);
      ru_o  = {16'($urandom), $urandom, $urandom};
      @(negedge clk);
      model_step();
      next_cycle();
    end
    stall = 1'b0;
    req   = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
